sd_crc_engine: RTL and testbench
================================

// Module: sd_crc_engine
// PURPOSE
//  Parametrised multi-lane serial CRC generator/checker for the SD host (CMD line: CRC7; DAT lines: CRC16 x4).
//  Each lane runs an independent CRC over a framed payload of LEN bits.
//  Generate mode: forwards the payload, then appends each lane's CRC MSB-first.
//  Check mode: compares the trailing CRC_W received bits per lane against the computed CRC and reports pass/fail.
// PARAMETERS
//  CRC_W  16       CRC width in bits (7 for CMD, 16 for DAT)
//  POLY   16'h1021 generator polynomial, implicit x^CRC_W term omitted (CRC7 uses 7'h09)
//  LANES  4        number of independent serial lanes
//  INIT   0        CRC register value loaded at start
//  LEN_W  16       width of the len input
// PORTS
//  clk        in   1               clock
//  rst        in   1               synchronous active-high reset
//  start      in   1               1-cycle pulse: latch mode/len, load INIT, enter DATA
//  mode       in   1               0 = generate, 1 = check; sampled on start
//  len        in   LEN_W           payload bits per lane; sampled on start
//  din        in   LANES           one bit per lane (bit i = lane i)
//  din_valid  in   1               bit strobe; state advances only when high
//  dout       out  LANES           registered output bits
//  dout_valid out  1               dout qualifier
//  busy       out  1               high in DATA or TAIL
//  done       out  1               1-cycle pulse on frame end
//  crc_ok     out  1               check-mode result, all lanes matched
//  lane_err   out  LANES           per-lane mismatch flags (check mode)
//  crc_out    out  LANES*CRC_W     live CRC registers; lane i at [i*CRC_W +: CRC_W]
// BEHAVIOUR
//  Reset: FSM=IDLE; all CRC regs=INIT; dout=0; dout_valid=0; busy=0; done=0; crc_ok=0; lane_err=0.
//  CRC step per lane on a DATA strobe:
//   fb = din[i] ^ crc[i][CRC_W-1]
//   crc[i] <= {crc[i][CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0)
//  FSM states and transitions:
//   IDLE -> DATA on start; go straight to TAIL instead if len == 0.
//   DATA: on each strobe, step the CRCs and decrement the bit counter; -> TAIL after the len-th strobe.
//   TAIL: CRC_W strobes, index k = CRC_W-1 down to 0; -> IDLE after the last one, with done=1 for one cycle.
//  TAIL, generate mode: dout[i] <= crc[i][k]; crc regs frozen.
//  TAIL, check mode: lane_err[i] |= din[i] ^ crc[i][k]; crc regs frozen.
//  Output timing:
//   dout / dout_valid are registered, 1-cycle latency from the strobe.
//   DATA: dout <= din, dout_valid <= din_valid.
//   TAIL: dout_valid <= din_valid (gen mode), 0 (check mode).
//   IDLE: dout_valid <= 0.
//  done: asserted the cycle after the final TAIL strobe.
//   crc_ok = ~|lane_err, updated with done.
//   crc_ok and lane_err hold until the next start.
//   In gen mode crc_ok is forced to 1.
//  din_valid low stalls every state with no change; no timeout.
//  start while busy: aborts the frame, reloads INIT, clears lane_err/crc_ok, begins the new frame; no done for the aborted frame.
//  start and din_valid in the same cycle: start wins; that din bit is ignored.
//  rst mid-frame: immediate return to reset state; no done.
//  crc_out is valid after done, until the next start.
// TESTING
//  1. CRC_W=7, POLY=7'h09, LANES=1, gen, len=40, bits of 40 00 00 00 00 (CMD0)
//     -> tail bits 1001010 (0x4A), done after 47 strobes.
//  2. CRC_W=16, POLY=16'h1021, LANES=1, gen, len=4096 all ones
//     -> crc_out=16'h7FA1 and 7FA1 emitted MSB-first.
//  3. LANES=4, check, 128 bytes 0xFF per lane, correct CRCs except one flipped bit on lane 2
//     -> crc_ok=0, lane_err=4'b0100.
//  4. len=0 gen -> 16 tail bits of INIT (0), then done; stalls with din_valid=0 mid-DATA leave crc_out unchanged.
//  5. start at DATA bit 10, then a fresh 40-bit CMD0 frame -> no done for the first frame; second frame gives 0x4A.
//  6. rst at TAIL bit 3 -> busy=0, dout_valid=0, crc_out=INIT next cycle; a subsequent frame is correct.

Source files
------------

// File: rtl/sd_crc_engine.sv
// Multi-lane serial CRC generator/checker for the SD host CMD/DAT lines.
// Every lane runs its own MSB-first CRC over a LEN-bit payload, then either emits or checks CRC_W tail bits.
module sd_crc_engine #(
    parameter int                 CRC_W = 16,
    parameter logic [CRC_W-1:0]   POLY  = 16'h1021,
    parameter int                 LANES = 4,
    parameter logic [CRC_W-1:0]   INIT  = '0,
    parameter int                 LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [LEN_W-1:0]         len,
    input  logic [LANES-1:0]         din,
    input  logic                     din_valid,
    output logic [LANES-1:0]         dout,
    output logic                     dout_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     crc_ok,
    output logic [LANES-1:0]         lane_err,
    output logic [LANES*CRC_W-1:0]   crc_out
);

    localparam int             KW    = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [KW-1:0]  K_MAX = KW'(CRC_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TAIL
    } state_t;

    state_t             state_q;
    logic               mode_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [KW-1:0]      k_q;
    logic [CRC_W-1:0]   crc_q [LANES];
    logic [LANES-1:0]   dout_q;
    logic               dout_valid_q;
    logic               done_q;
    logic               crc_ok_q;
    logic [LANES-1:0]   lane_err_q;

    logic [CRC_W-1:0]   crc_step_d [LANES];
    logic [LANES-1:0]   tail_bit;
    logic [LANES-1:0]   lane_err_d;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic fb;
            assign fb             = din[gi] ^ crc_q[gi][CRC_W-1];
            assign crc_step_d[gi] = {crc_q[gi][CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            // k_q walks the frozen register MSB-first during the tail
            assign tail_bit[gi]   = crc_q[gi][k_q];
            assign crc_out[gi*CRC_W +: CRC_W] = crc_q[gi];
        end
    endgenerate

    assign lane_err_d = lane_err_q | (din ^ tail_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
            k_q          <= K_MAX;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            crc_ok_q     <= 1'b0;
            lane_err_q   <= '0;
            for (int l = 0; l < LANES; l++) crc_q[l] <= INIT;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // A start always wins: it aborts any frame in flight without a done
                mode_q       <= mode;
                cnt_q        <= len;
                k_q          <= K_MAX;
                dout_valid_q <= 1'b0;
                crc_ok_q     <= 1'b0;
                lane_err_q   <= '0;
                for (int l = 0; l < LANES; l++) crc_q[l] <= INIT;
                state_q      <= (len == '0) ? S_TAIL : S_DATA;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        dout_valid_q <= 1'b0;
                    end
                    S_DATA: begin
                        dout_valid_q <= din_valid;
                        if (din_valid) begin
                            dout_q <= din;
                            for (int l = 0; l < LANES; l++) crc_q[l] <= crc_step_d[l];
                            cnt_q <= cnt_q - LEN_W'(1);
                            if (cnt_q == LEN_W'(1)) begin
                                state_q <= S_TAIL;
                                k_q     <= K_MAX;
                            end
                        end
                    end
                    S_TAIL: begin
                        dout_valid_q <= din_valid & ~mode_q;
                        if (din_valid) begin
                            if (mode_q) lane_err_q <= lane_err_d;
                            else        dout_q     <= tail_bit;
                            if (k_q == '0) begin
                                state_q  <= S_IDLE;
                                done_q   <= 1'b1;
                                crc_ok_q <= mode_q ? ~|lane_err_d : 1'b1;
                            end else begin
                                k_q <= k_q - KW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        dout_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign crc_ok     = crc_ok_q;
    assign lane_err   = lane_err_q;

endmodule

// File: tb/tb_sd_crc_engine.sv
// Bench for sd_crc_engine: a CRC7 CMD instance and a 4-lane CRC16 DAT instance,
// with dout scoreboards fed at drive time and drained by negedge monitors.
module tb_sd_crc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // CMD instance (CRC7, one lane)
    logic        c_start, c_mode, c_din_valid;
    logic [15:0] c_len;
    logic [0:0]  c_din, c_dout, c_lane_err;
    logic        c_dout_valid, c_busy, c_done, c_crc_ok;
    logic [6:0]  c_crc_out;

    // DAT instance (CRC16, four lanes)
    logic        d_start, d_mode, d_din_valid;
    logic [15:0] d_len;
    logic [3:0]  d_din, d_dout, d_lane_err;
    logic        d_dout_valid, d_busy, d_done, d_crc_ok;
    logic [63:0] d_crc_out;

    sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .LANES(1), .INIT(7'h00), .LEN_W(16)) u_cmd (
        .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .len(c_len),
        .din(c_din), .din_valid(c_din_valid), .dout(c_dout), .dout_valid(c_dout_valid),
        .busy(c_busy), .done(c_done), .crc_ok(c_crc_ok), .lane_err(c_lane_err),
        .crc_out(c_crc_out)
    );

    sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .LANES(4), .INIT(16'h0000), .LEN_W(16)) u_dat (
        .clk(clk), .rst(rst), .start(d_start), .mode(d_mode), .len(d_len),
        .din(d_din), .din_valid(d_din_valid), .dout(d_dout), .dout_valid(d_dout_valid),
        .busy(d_busy), .done(d_done), .crc_ok(d_crc_ok), .lane_err(d_lane_err),
        .crc_out(d_crc_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int c_done_cnt = 0;
    int d_done_cnt = 0;

    logic       c_q[$];
    logic [3:0] d_q[$];
    logic [6:0]  c_model;
    logic [15:0] d_model [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [63:0] d_model_cat();
        return {d_model[3], d_model[2], d_model[1], d_model[0]};
    endfunction

    // Scoreboard drain: every valid dout must match the oldest expected bit
    always @(negedge clk) begin
        if (c_dout_valid === 1'b1) begin
            if (c_q.size() == 0) check_eq("cmd_dout_unexpected", c_dout_valid, 1'b0);
            else                 check_eq("cmd_dout", c_dout, c_q.pop_front());
        end
        if (d_dout_valid === 1'b1) begin
            if (d_q.size() == 0) check_eq("dat_dout_unexpected", d_dout_valid, 1'b0);
            else                 check_eq("dat_dout", d_dout, d_q.pop_front());
        end
        if (c_done === 1'b1) c_done_cnt++;
        if (d_done === 1'b1) d_done_cnt++;
    end

    task automatic c_drive(input logic st, input logic md, input int ln, input logic dv, input logic b);
        c_start = st; c_mode = md; c_len = 16'(ln); c_din_valid = dv; c_din[0] = b;
        @(negedge clk);
    endtask

    task automatic d_drive(input logic st, input logic md, input int ln, input logic dv, input logic [3:0] b);
        d_start = st; d_mode = md; d_len = 16'(ln); d_din_valid = dv; d_din = b;
        @(negedge clk);
    endtask

    task automatic c_data(input logic b);
        c_q.push_back(b);
        c_model = crc7_step(c_model, b);
        c_drive(1'b0, 1'b0, 0, 1'b1, b);
    endtask

    task automatic d_data(input logic [3:0] b);
        d_q.push_back(b);
        for (int l = 0; l < 4; l++) d_model[l] = crc16_step(d_model[l], b[l]);
        d_drive(1'b0, 1'b0, 0, 1'b1, b);
    endtask

    task automatic d_start_frame(input logic md, input int ln);
        for (int l = 0; l < 4; l++) d_model[l] = 16'h0000;
        d_drive(1'b1, md, ln, 1'b0, 4'h0);
    endtask

    // Gen-mode tail: expected bits come from exp_cat, MSB-first per lane
    task automatic d_tail_gen(input string tag, input logic [63:0] exp_cat);
        logic [3:0] bits;
        int d0;
        d0 = d_done_cnt;
        for (int k = 15; k >= 0; k--) begin
            for (int l = 0; l < 4; l++) bits[l] = exp_cat[l*16 + k];
            d_q.push_back(bits);
            d_drive(1'b0, 1'b0, 0, 1'b1, 4'h0);
        end
        check_eq({tag, "_done"}, d_done, 1'b1);
        check_eq({tag, "_crc_ok"}, d_crc_ok, 1'b1);
        check_eq({tag, "_busy_end"}, d_busy, 1'b0);
        d_drive(1'b0, 1'b0, 0, 1'b0, 4'h0);
        check_eq({tag, "_done_pulses"}, 64'(d_done_cnt - d0), 1);
        check_eq({tag, "_q_empty"}, 64'(d_q.size()), 0);
        $display("dat frame %s: crc_out=%016h crc_ok=%0b", tag, d_crc_out, d_crc_ok);
    endtask

    // Full CMD0 frame; start is driven together with a strobe that must be ignored
    task automatic cmd0_frame(input string tag);
        logic [39:0] msg;
        logic [6:0]  exp_crc;
        int d0;
        msg = 40'h40_0000_0000;
        exp_crc = 7'h4A;
        d0 = c_done_cnt;
        c_model = 7'h00;
        c_drive(1'b1, 1'b0, 40, 1'b1, 1'b1);
        check_eq({tag, "_busy_start"}, c_busy, 1'b1);
        check_eq({tag, "_crc_ok_cleared"}, c_crc_ok, 1'b0);
        for (int i = 39; i >= 0; i--) c_data(msg[i]);
        check_eq({tag, "_crc_after_data"}, c_crc_out, exp_crc);
        for (int k = 6; k >= 0; k--) begin
            if (k == 0) check_eq({tag, "_no_early_done"}, c_done, 1'b0);
            c_q.push_back(exp_crc[k]);
            c_drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        check_eq({tag, "_done"}, c_done, 1'b1);
        check_eq({tag, "_crc_out"}, c_crc_out, exp_crc);
        check_eq({tag, "_crc_ok"}, c_crc_ok, 1'b1);
        check_eq({tag, "_busy_end"}, c_busy, 1'b0);
        c_drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_eq({tag, "_done_pulses"}, 64'(c_done_cnt - d0), 1);
        check_eq({tag, "_done_low"}, c_done, 1'b0);
        check_eq({tag, "_q_empty"}, 64'(c_q.size()), 0);
        $display("cmd frame %s: crc_out=%02h", tag, c_crc_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  bits;
        logic [63:0] snap;
        int d0;
        rst = 1'b1;
        c_start = 0; c_mode = 0; c_len = 0; c_din = '0; c_din_valid = 0;
        d_start = 0; d_mode = 0; d_len = 0; d_din = '0; d_din_valid = 0;
        c_model = '0;
        for (int l = 0; l < 4; l++) d_model[l] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_c_busy", c_busy, 1'b0);
        check_eq("rst_c_dout_valid", c_dout_valid, 1'b0);
        check_eq("rst_c_done", c_done, 1'b0);
        check_eq("rst_c_crc_ok", c_crc_ok, 1'b0);
        check_eq("rst_c_crc_out", c_crc_out, 7'h00);
        check_eq("rst_d_lane_err", d_lane_err, 4'h0);
        check_eq("rst_d_dout", d_dout, 4'h0);
        check_eq("rst_d_crc_out", d_crc_out, 64'h0);

        // CMD0 CRC7
        cmd0_frame("cmd0");

        // Abort at DATA bit 10, then a fresh CMD0 frame
        d0 = c_done_cnt;
        c_model = 7'h00;
        c_drive(1'b1, 1'b0, 40, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) c_data(i == 1);
        cmd0_frame("abort_restart");
        check_eq("abort_no_extra_done", 64'(c_done_cnt - d0), 1);

        // rst in the tail, then a clean frame
        d0 = c_done_cnt;
        c_model = 7'h00;
        c_drive(1'b1, 1'b0, 40, 1'b0, 1'b0);
        for (int i = 39; i >= 0; i--) c_data(i == 38);
        for (int k = 6; k >= 4; k--) begin
            c_q.push_back(c_model[k]);
            c_drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        rst = 1'b1;
        c_drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        check_eq("rst_mid_busy", c_busy, 1'b0);
        check_eq("rst_mid_dout_valid", c_dout_valid, 1'b0);
        check_eq("rst_mid_crc_out", c_crc_out, 7'h00);
        check_eq("rst_mid_done", c_done, 1'b0);
        cmd0_frame("after_rst");
        check_eq("rst_mid_no_done", 64'(c_done_cnt - d0), 1);

        // 4096 ones on every DAT lane
        d_start_frame(1'b0, 4096);
        for (int i = 0; i < 4096; i++) d_data(4'hF);
        check_eq("ones4096_crc_out", d_crc_out, {4{16'h7FA1}});
        d_tail_gen("ones4096", {4{16'h7FA1}});

        // Check mode: 1024 ones, correct CRC except one flipped tail bit on lane 2
        d_start_frame(1'b1, 1024);
        for (int i = 0; i < 1024; i++) d_data(4'hF);
        d0 = d_done_cnt;
        for (int k = 15; k >= 0; k--) begin
            for (int l = 0; l < 4; l++) bits[l] = d_model[l][k];
            if (k == 5) bits[2] = ~bits[2];
            d_drive(1'b0, 1'b0, 0, 1'b1, bits);
        end
        check_eq("chk_done", d_done, 1'b1);
        check_eq("chk_crc_ok", d_crc_ok, 1'b0);
        check_eq("chk_lane_err", d_lane_err, 4'b0100);
        check_eq("chk_crc_out", d_crc_out, d_model_cat());
        d_drive(1'b0, 1'b0, 0, 1'b0, 4'h0);
        check_eq("chk_hold_lane_err", d_lane_err, 4'b0100);
        check_eq("chk_done_pulses", 64'(d_done_cnt - d0), 1);
        $display("dat frame check: crc_ok=%0b lane_err=%04b", d_crc_ok, d_lane_err);

        // len = 0: tail of INIT straight away
        d_start_frame(1'b0, 0);
        check_eq("len0_lane_err_cleared", d_lane_err, 4'h0);
        check_eq("len0_busy", d_busy, 1'b1);
        d_tail_gen("len0", 64'h0);

        // Stalls mid-DATA leave the CRCs untouched
        d_start_frame(1'b0, 8);
        d_data(4'b1010); d_data(4'b0110); d_data(4'b1111);
        check_eq("stall_crc_before", d_crc_out, d_model_cat());
        for (int i = 0; i < 5; i++) begin
            d_drive(1'b0, 1'b0, 0, 1'b0, 4'hF);
            check_eq("stall_dout_valid", d_dout_valid, 1'b0);
        end
        check_eq("stall_crc_after", d_crc_out, d_model_cat());
        check_eq("stall_busy", d_busy, 1'b1);
        for (int i = 0; i < 5; i++) d_data(4'(i * 3 + 1));
        snap = d_model_cat();
        check_eq("stall_crc_final", d_crc_out, snap);
        d_tail_gen("stall", snap);

        // Independent random payloads per lane
        d_start_frame(1'b0, 64);
        for (int i = 0; i < 64; i++) d_data(4'($urandom_range(0, 15)));
        snap = d_model_cat();
        check_eq("rand_crc_out", d_crc_out, snap);
        d_tail_gen("rand", snap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
